// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet-granular AXI-Stream arbiter.
// The state enum is also what the Busy output reflects.
package axis_arb_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;

   // Index width for a source count; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/axis_packet_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester searching upward
// from (ptr_i + 1) mod NUM_SRC, returned one-hot.
module rr_pick #(
   parameter int NUM_SRC = 2,
   parameter int IDX_W   = 1
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic [NUM_SRC-1:0] pick_o,
   output logic               found_o
);

   logic [IDX_W-1:0] idx;

   always_comb begin
      pick_o  = '0;
      found_o = 1'b0;
      idx     = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         idx = IDX_W'((int'(ptr_i) + k) % NUM_SRC);
         if (!found_o && req_i[idx]) begin
            pick_o[idx] = 1'b1;
            found_o     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter: one source owns the master port from
// grant until its tlast handshake; completed packets are counted.
module axis_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int NUM_SRC = 2,
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 16
) (
   input  logic                      Clk,
   input  logic                      ResetN,
   input  logic                      En,
   input  logic [NUM_SRC-1:0]        S_AXIS_tvalid,
   output logic [NUM_SRC-1:0]        S_AXIS_tready,
   input  logic [NUM_SRC-1:0]        S_AXIS_tlast,
   input  logic [NUM_SRC*DATA_W-1:0] S_AXIS_tdata,
   output logic                      M_AXIS_tvalid,
   input  logic                      M_AXIS_tready,
   output logic                      M_AXIS_tlast,
   output logic [DATA_W-1:0]         M_AXIS_tdata,
   output logic [NUM_SRC-1:0]        Grant,
   output logic                      Busy,
   output logic [CNT_W-1:0]          PacketCount
);

   localparam int IdxW = idx_width(NUM_SRC);

   arb_state_e         state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   logic [IdxW-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]    gidx;
   logic [NUM_SRC-1:0] pick;
   logic               found;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IdxW)
   ) u_pick (
      .req_i   (S_AXIS_tvalid),
      .ptr_i   (ptr_q),
      .pick_o  (pick),
      .found_o (found)
   );

   always_comb begin
      gidx = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q[i]) gidx = IdxW'(i);
      end
   end

   // Valid/ready contract: a beat moves when valid and ready are both high
   // on a rising edge; only the granted source ever sees ready, and it sees
   // the downstream ready directly so no beat is buffered here.
   always_comb begin
      M_AXIS_tvalid = 1'b0;
      M_AXIS_tlast  = 1'b0;
      M_AXIS_tdata  = '0;
      S_AXIS_tready = '0;
      if (state_q == ST_LOCKED) begin
         M_AXIS_tvalid       = S_AXIS_tvalid[gidx];
         M_AXIS_tlast        = S_AXIS_tlast[gidx];
         M_AXIS_tdata        = S_AXIS_tdata[gidx*DATA_W +: DATA_W];
         S_AXIS_tready[gidx] = M_AXIS_tready;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (En && found) begin
               grant_d = pick;
               state_d = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            // Only the closing beat releases the lock; En is ignored here.
            if (M_AXIS_tvalid && M_AXIS_tready && M_AXIS_tlast) begin
               ptr_d   = gidx;
               cnt_d   = cnt_q + CNT_W'(1);
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         ptr_q   <= IdxW'(NUM_SRC - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Grant       = grant_q;
   assign Busy        = (state_q == ST_LOCKED);
   assign PacketCount = cnt_q;

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter: cycle model of the arbitration rules
// plus literal expectations on beat order, grant order and turnaround.
module tb_axis_packet_arbiter;

   localparam int N  = 2;
   localparam int W  = 8;
   localparam int CW = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          en;
   logic          m_ready;
   logic [N-1:0]  s_tvalid;
   logic [N-1:0]  s_tlast;
   logic [N*W-1:0] s_tdata;

   logic [N-1:0]  S_AXIS_tready;
   logic          M_AXIS_tvalid;
   logic          M_AXIS_tlast;
   logic [W-1:0]  M_AXIS_tdata;
   logic [N-1:0]  Grant;
   logic          Busy;
   logic [CW-1:0] PacketCount;

   axis_packet_arbiter #(
      .NUM_SRC (N),
      .DATA_W  (W),
      .CNT_W   (CW)
   ) dut (
      .Clk           (clk),
      .ResetN        (rst_n),
      .En            (en),
      .S_AXIS_tvalid (s_tvalid),
      .S_AXIS_tready (S_AXIS_tready),
      .S_AXIS_tlast  (s_tlast),
      .S_AXIS_tdata  (s_tdata),
      .M_AXIS_tvalid (M_AXIS_tvalid),
      .M_AXIS_tready (m_ready),
      .M_AXIS_tlast  (M_AXIS_tlast),
      .M_AXIS_tdata  (M_AXIS_tdata),
      .Grant         (Grant),
      .Busy          (Busy),
      .PacketCount   (PacketCount)
   );

   // ---------------- bookkeeping ----------------
   int checks = 0;
   int passes = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic fail_timeout(input string name);
      checks++;
      $display("FAIL timeout_%s: condition not reached within budget (t=%0t)", name, $time);
   endtask

   function automatic logic bit_of(input logic [N-1:0] v, input int i);
      logic [N-1:0] t;
      t = v >> i;
      return t[0];
   endfunction

   // ---------------- source drivers ----------------
   logic [W:0]   src_q [N][$];   // {last, data}
   logic [N-1:0] hs = '0;
   bit           gap_en = 0;
   bit           tog_en = 0;

   always @(posedge clk) begin
      logic [W:0] b;
      #1;
      if (tog_en) m_ready = ~m_ready;
      for (int i = 0; i < N; i++) begin
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         if (gap_en && (hs[i] || !s_tvalid[i]) && ((cyc + i) % 3 == 0)) begin
            s_tvalid[i] = 1'b0;
         end else if (src_q[i].size() > 0) begin
            b = src_q[i][0];
            s_tvalid[i]        = 1'b1;
            s_tlast[i]         = b[W];
            s_tdata[i*W +: W]  = b[W-1:0];
         end else begin
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
         end
      end
   end

   // ---------------- model + compare (negedge) ----------------
   int            m_g = -1;       // granted source, -1 when idle
   int            m_ptr = N - 1;
   logic [CW-1:0] m_cnt = '0;

   logic [W-1:0]  mlog[$];
   logic [N-1:0]  ghist[$];
   int            rise_cyc[$];
   int            last_cyc[$];
   int            en_rise_cyc = 0;
   logic          en_prev = 1'b0;
   logic [N-1:0]  grant_prev = '0;

   always @(negedge clk) begin
      logic [N-1:0] e_grant, e_sready;
      logic         e_mv, e_ml, busy;
      logic [N*W-1:0] sh;
      cyc++;
      for (int i = 0; i < N; i++) hs[i] = s_tvalid[i] & S_AXIS_tready[i];

      if (!rst_n) begin
         m_g = -1; m_ptr = N - 1; m_cnt = '0;
         chk("rst_grant", 32'(Grant), 32'(0));
         chk("rst_busy", 32'(Busy), 32'(0));
         chk("rst_mvalid", 32'(M_AXIS_tvalid), 32'(0));
         chk("rst_sready", 32'(S_AXIS_tready), 32'(0));
         chk("rst_count", 32'(PacketCount), 32'(0));
      end else begin
         busy     = (m_g >= 0);
         e_grant  = busy ? (N'(1) << m_g) : '0;
         e_mv     = busy && bit_of(s_tvalid, m_g);
         e_ml     = busy && bit_of(s_tlast, m_g);
         e_sready = (busy && m_ready) ? (N'(1) << m_g) : '0;
         chk("grant", 32'(Grant), 32'(e_grant));
         chk("busy", 32'(Busy), 32'(busy));
         chk("m_tvalid", 32'(M_AXIS_tvalid), 32'(e_mv));
         chk("s_tready", 32'(S_AXIS_tready), 32'(e_sready));
         chk("count", 32'(PacketCount), 32'(m_cnt));
         if (e_mv) begin
            sh = s_tdata >> (m_g * W);
            chk("m_tlast", 32'(M_AXIS_tlast), 32'(e_ml));
            chk("m_tdata", 32'(M_AXIS_tdata), 32'(sh[W-1:0]));
         end
         // model advance to the state after the coming rising edge
         if (busy) begin
            if (e_mv && m_ready && e_ml) begin
               m_ptr = m_g;
               m_cnt = m_cnt + 1'b1;
               m_g   = -1;
            end
         end else if (en && (s_tvalid != '0)) begin
            for (int k = 1; k <= N; k++) begin
               if (m_g < 0 && bit_of(s_tvalid, (m_ptr + k) % N)) m_g = (m_ptr + k) % N;
            end
         end
      end

      if (M_AXIS_tvalid && m_ready) begin
         mlog.push_back(M_AXIS_tdata);
         if (M_AXIS_tlast) last_cyc.push_back(cyc);
      end
      if (Grant != '0 && grant_prev == '0) begin
         ghist.push_back(Grant);
         rise_cyc.push_back(cyc);
      end
      if (en && !en_prev) en_rise_cyc = cyc;
      grant_prev = Grant;
      en_prev    = en;
   end

   // ---------------- tasks ----------------
   logic [W-1:0] exp_q[$];
   logic [N-1:0] exp_g[$];

   task automatic clear_logs();
      mlog.delete(); ghist.delete(); rise_cyc.delete(); last_cyc.delete();
      exp_q.delete(); exp_g.delete();
   endtask

   task automatic flush_srcs();
      for (int i = 0; i < N; i++) src_q[i].delete();
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      flush_srcs();
      gap_en = 0; tog_en = 0; m_ready = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      clear_logs();
   endtask

   task automatic push_pkt(input int src, input logic [W-1:0] base, input int len);
      for (int k = 0; k < len; k++) src_q[src].push_back({(k == len - 1), base + W'(k)});
   endtask

   task automatic wait_mlog(input int n, input int budget, input string name);
      int t = 0;
      while (mlog.size() < n && t < budget) begin
         @(posedge clk); #2;
         t++;
      end
      if (mlog.size() < n) fail_timeout(name);
   endtask

   task automatic wait_cnt(input logic [CW-1:0] n, input int budget, input string name);
      int t = 0;
      while (PacketCount !== n && t < budget) begin
         @(posedge clk); #2;
         t++;
      end
      if (PacketCount !== n) fail_timeout(name);
   endtask

   task automatic check_logs(input string name);
      chk({name, "_beats"}, 32'(mlog.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < mlog.size(); i++)
         chk({name, "_beat"}, 32'(mlog[i]), 32'(exp_q[i]));
      chk({name, "_grants"}, 32'(ghist.size()), 32'(exp_g.size()));
      for (int i = 0; i < exp_g.size() && i < ghist.size(); i++)
         chk({name, "_gorder"}, 32'(ghist[i]), 32'(exp_g[i]));
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #2;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      en = 1'b0; m_ready = 1'b0;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0;

      // T1: single source, two 7-beat packets back to back
      do_reset();
      chk("t1_rst_grant", 32'(Grant), 32'(0));
      chk("t1_rst_busy", 32'(Busy), 32'(0));
      chk("t1_rst_count", 32'(PacketCount), 32'(0));
      en = 1'b1;
      push_pkt(0, 8'h00, 7);
      push_pkt(0, 8'h10, 7);
      wait_mlog(14, 100, "t1");
      settle();
      for (int k = 0; k < 7; k++) exp_q.push_back(8'(k));
      for (int k = 0; k < 7; k++) exp_q.push_back(8'h10 + 8'(k));
      exp_g = '{2'b01, 2'b01};
      check_logs("t1");
      chk("t1_count", 32'(PacketCount), 32'd2);
      if (rise_cyc.size() > 1 && last_cyc.size() > 0)
         chk("t1_bubble", 32'(rise_cyc[1] - last_cyc[0]), 32'd2);
      else fail_timeout("t1_bubble");

      // T2: both sources continuously valid, 3-beat packets alternate
      do_reset();
      push_pkt(0, 8'h00, 3); push_pkt(0, 8'h03, 3);
      push_pkt(1, 8'h10, 3); push_pkt(1, 8'h13, 3);
      wait_mlog(12, 200, "t2");
      settle();
      exp_q = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12,
                8'h03, 8'h04, 8'h05, 8'h13, 8'h14, 8'h15};
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      check_logs("t2");
      chk("t2_count", 32'(PacketCount), 32'd4);

      // T3: source 1 requests while source 0 is mid-packet
      do_reset();
      push_pkt(0, 8'h20, 5);
      wait_mlog(2, 50, "t3a");
      push_pkt(1, 8'h30, 3);
      wait_mlog(8, 100, "t3b");
      settle();
      exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h30, 8'h31, 8'h32};
      exp_g = '{2'b01, 2'b10};
      check_logs("t3");

      // T4: En dropped during beat 2 of 5
      do_reset();
      push_pkt(0, 8'h40, 5);
      wait_mlog(1, 50, "t4a");
      en = 1'b0;
      push_pkt(0, 8'h48, 2);
      wait_cnt(16'd1, 50, "t4b");
      repeat (6) @(posedge clk);
      #2;
      chk("t4_no_regrant", 32'(ghist.size()), 32'd1);
      chk("t4_idle_busy", 32'(Busy), 32'd0);
      en = 1'b1;
      wait_mlog(7, 50, "t4c");
      settle();
      exp_q = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h49};
      exp_g = '{2'b01, 2'b01};
      check_logs("t4");
      if (rise_cyc.size() > 1) chk("t4_regrant_lat", 32'(rise_cyc[1] - en_rise_cyc), 32'd1);
      else fail_timeout("t4_regrant_lat");
      chk("t4_count", 32'(PacketCount), 32'd2);

      // T5: downstream ready toggling, source valid gaps
      do_reset();
      gap_en = 1; tog_en = 1;
      push_pkt(0, 8'h50, 6);
      push_pkt(1, 8'h60, 4);
      wait_mlog(10, 300, "t5");
      gap_en = 0; tog_en = 0;
      settle();
      m_ready = 1'b1;
      exp_q = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55,
                8'h60, 8'h61, 8'h62, 8'h63};
      exp_g = '{2'b01, 2'b10};
      check_logs("t5");
      chk("t5_count", 32'(PacketCount), 32'd2);

      // T6: single-beat packet, then reset mid-packet; source 0 wins afterwards
      clear_logs();
      push_pkt(0, 8'h70, 1);
      push_pkt(0, 8'h80, 8);
      wait_mlog(4, 50, "t6a");
      chk("t6_single_count", 32'(PacketCount), 32'd3);
      if (rise_cyc.size() > 1 && last_cyc.size() > 0)
         chk("t6_single_bubble", 32'(rise_cyc[1] - last_cyc[0]), 32'd2);
      else fail_timeout("t6_single_bubble");
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_grant", 32'(Grant), 32'd0);
      chk("t6_rst_busy", 32'(Busy), 32'd0);
      chk("t6_rst_count", 32'(PacketCount), 32'd0);
      chk("t6_rst_mvalid", 32'(M_AXIS_tvalid), 32'd0);
      chk("t6_no_partial_last", 32'(last_cyc.size()), 32'd1);
      flush_srcs();
      @(posedge clk); #2;
      clear_logs();
      push_pkt(0, 8'h90, 2);
      push_pkt(1, 8'hA0, 2);
      @(posedge clk); #2;
      rst_n = 1'b1;
      wait_mlog(4, 50, "t6b");
      settle();
      exp_q = '{8'h90, 8'h91, 8'hA0, 8'hA1};
      exp_g = '{2'b01, 2'b10};
      check_logs("t6");
      chk("t6_count", 32'(PacketCount), 32'd2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter that shares one AXI-Stream master port among up to NUM_SRC stream sources, e.g. several sample generators feeding the image rotator input. A grant is taken only between packets and held until the granted source completes its `tlast` beat. No packet is ever interleaved. The block also counts completed packets for status readback.

## Interface
- NUM_SRC, 2, number of slave streams (2..4)
- DATA_W, 8, tdata width in bits
- CNT_W, 16, width of PacketCount
---
- Clk  in  1  single clock; all state on rising edge
- ResetN  in  1  asynchronous, active-low reset
- En  in  1  arbitration enable; low blocks new grants only
- S_AXIS_tvalid  in  NUM_SRC  per-source valid
- S_AXIS_tready  out  NUM_SRC  per-source ready
- S_AXIS_tlast  in  NUM_SRC  per-source last
- S_AXIS_tdata  in  NUM_SRC*DATA_W  source i occupies bits [i*DATA_W +: DATA_W]
- M_AXIS_tvalid  out  1  master valid
- M_AXIS_tready  in  1  downstream ready
- M_AXIS_tlast  out  1  master last
- M_AXIS_tdata  out  DATA_W  master data
- Grant  out  NUM_SRC  registered one-hot grant; all-zero when idle
- Busy  out  1  high while a packet is locked
- PacketCount  out  CNT_W  completed master packets, wraps

## Operation
- States: IDLE, LOCKED.
- IDLE:
  - All S_AXIS_tready = 0, M_AXIS_tvalid = 0, Grant = 0.
  - If En = 1 and any S_AXIS_tvalid = 1: select the first requester searching upward from (Ptr+1) mod NUM_SRC.
  - Register Grant and go to LOCKED.
- LOCKED, granted index g:
  - M_AXIS_tvalid/tlast/tdata = source g's signals.
  - S_AXIS_tready[g] = M_AXIS_tready; all other readies = 0.
- On a master handshake (M_AXIS_tvalid & M_AXIS_tready) with M_AXIS_tlast = 1:
  - Ptr <= g, PacketCount <= PacketCount+1 (mod 2^CNT_W).
  - Return to IDLE.
- Grant never changes mid-packet, regardless of En, other tvalids or source g dropping tvalid.
- En = 0 in LOCKED: current packet completes normally; no re-grant afterwards until En = 1.
- Source g deasserts tvalid mid-packet: master tvalid drops and the lock is held.
- Requests during IDLE with En = 0 are ignored, not latched.

## Timing
- Reset values: state IDLE, Grant 0, Busy 0, M_AXIS_tvalid 0, all S_AXIS_tready 0, PacketCount 0, Ptr NUM_SRC-1 (source 0 has first priority).
- Grant latency: tvalid seen in IDLE at edge n -> Grant/Busy high after edge n, first beat can transfer in cycle n+1.
- Data path is combinational (zero-latency mux) in LOCKED. M_AXIS_tready -> S_AXIS_tready is a combinational path.
- Turnaround: the tlast handshake cycle is followed by exactly one IDLE cycle (bubble) before the next grant. Sustained throughput is L/(L+1) for packets of L beats.
- Single-beat packet (tvalid & tlast together): grant cycle, one transfer cycle, one IDLE cycle.
- ResetN asserted mid-packet: immediate return to reset values; the partial packet is abandoned with no master tlast.

## Structure
- Package axis_arb_pkg holds:
  - state enum (IDLE, LOCKED)
  - index width localparam helper (clog2 of NUM_SRC)
- Sub-module rr_pick: combinational round-robin selector (Req, Ptr -> one-hot Pick, Found).
- Top holds the FSM, Ptr, Grant register, mux and counter.

## Test plan
- Reset then single source 0 sending 7-beat packets, data 0..6, tready=1 -> Grant=01, master data 0..6, tlast on beat 7, PacketCount=1, one idle cycle, regrant 01.
- Both sources valid continuously, 3-beat packets -> grants alternate 01,10,01,10. After 4 packets PacketCount=4 and no beats are interleaved.
- Source 1 raises tvalid while source 0 is mid-packet -> source 0's packet completes unbroken and source 1 is granted next.
- En dropped on beat 2 of 5 -> packet finishes (tlast, PacketCount+1). No further grant while En=0; re-grant one cycle after En=1.
- Master tready toggled 1,0,1,0 and source tvalid gaps -> S_AXIS_tready[g] mirrors M_AXIS_tready, no beat lost or duplicated, lock held throughout.
- ResetN pulsed low mid-packet -> Grant=0, Busy=0, PacketCount=0 immediately. After release, source 0 wins the first arbitration.
